// File: rtl/opb_register_bank_simulink2ppc.sv
// opb_register_bank_simulink2ppc: OPB bank of C_NUM_CH captured user words with new/overflow flags and freeze.
// Define OPB_REG_BANK_ERRACK_EN to flag RO/reserved writes and out-of-range accesses with Sl_errAck.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01024100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010241FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_SIGN_EXT   = 0
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]        OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
    input  logic                             OPB_RNW,
    input  logic                             OPB_select,
    input  logic                             OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
    output logic                             Sl_xferAck,
    output logic                             Sl_errAck,
    output logic                             Sl_retry,
    output logic                             Sl_toutSup,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]              user_valid,
    output logic                             frozen
);
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state;
    logic freeze;
    logic [C_NUM_CH-1:0] new_q, ovf_q, rd_clr;
    logic [C_DATA_WIDTH-1:0] ch [C_NUM_CH];
    logic [31:0] off, rd_data;
    logic [29:0] word;
    logic in_win, go, rd_go, wr_go, ctrl_wr, clr_ovf, err;
    logic unused_ok;

    function automatic logic [31:0] ext(input logic [C_DATA_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[C_DATA_WIDTH-1:0] = v;
        if (C_SIGN_EXT != 0)
            for (int i = C_DATA_WIDTH; i < 32; i++) r[i] = v[C_DATA_WIDTH-1];
        return r;
    endfunction

    always_comb begin
        off     = OPB_ABus - C_BASEADDR;
        word    = off[31:2];
        in_win  = OPB_ABus >= C_BASEADDR && OPB_ABus <= C_HIGHADDR;
        go      = state == IDLE && OPB_select && in_win;
        rd_go   = go && OPB_RNW;
        wr_go   = go && !OPB_RNW;
        ctrl_wr = wr_go && word == 30'd0 && OPB_BE[3];
        clr_ovf = ctrl_wr && OPB_DBus[30];
        rd_data = word == 30'd0 ? {31'd0, freeze} :
                  word == 30'd1 ? (32'(ovf_q) << 16) | 32'(new_q) : 32'd0;
        rd_clr  = '0;
        for (int k = 0; k < C_NUM_CH; k++) begin
            rd_clr[k] = rd_go && word == 30'(4 + k);
            if (word == 30'(4 + k)) rd_data = ext(ch[k]);
        end
`ifdef OPB_REG_BANK_ERRACK_EN
        err = word >= 30'(4 + C_NUM_CH) || (!OPB_RNW && word != 30'd0);
`else
        err = 1'b0;
`endif
    end

    // Read data and flag clears act on the edge that raises the ack, so reads see pre-capture values.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state      <= IDLE;
            Sl_xferAck <= 1'b0;
            Sl_errAck  <= 1'b0;
            Sl_DBus    <= '0;
            freeze     <= 1'b0;
            new_q      <= '0;
            ovf_q      <= '0;
            for (int k = 0; k < C_NUM_CH; k++) ch[k] <= '0;
        end else begin
            state      <= go ? ACK : state == ACK ? HOLD : (state == HOLD && !OPB_select) ? IDLE : state;
            Sl_xferAck <= go;
            Sl_errAck  <= go && err;
            Sl_DBus    <= (rd_go && !err) ? rd_data : '0;
            if (ctrl_wr) freeze <= OPB_DBus[31];
            for (int k = 0; k < C_NUM_CH; k++) begin
                if (user_valid[k] && !freeze) ch[k] <= user_data_in[k*C_DATA_WIDTH +: C_DATA_WIDTH];
                new_q[k] <= (user_valid[k] && !freeze) || (new_q[k] && !rd_clr[k]);
                ovf_q[k] <= (user_valid[k] && (freeze || new_q[k])) || (ovf_q[k] && !clr_ovf);
            end
        end
    end

    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign frozen     = freeze;
    assign unused_ok  = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], off[1:0]};
endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// tb_opb_register_bank_simulink2ppc: randomized bench with a flag-level reference model;
// a second 12-bit sign-extending instance shares the bus to check read extension.
module tb_opb_register_bank_simulink2ppc;
    localparam int N = 4;
    localparam logic [31:0] BASE = 32'h01024100;

    logic clk = 1'b0, rst, rnw, sel, seq;
    logic [31:0] abus, dbus;
    logic [0:3] be;
    logic [0:31] dbo1, dbo2;
    logic ack1, err1, retry1, tout1, fr1, ack2, err2, retry2, tout2, fr2;
    logic [127:0] ud1;
    logic [47:0] ud2;
    logic [3:0] uv;
    int compared = 0, mismatched = 0;

    logic [31:0] m_ch [N];
    logic [3:0] m_new, m_ovf;
    logic m_fz;

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbo1), .Sl_xferAck(ack1),
        .Sl_errAck(err1), .Sl_retry(retry1), .Sl_toutSup(tout1), .user_data_in(ud1),
        .user_valid(uv), .frozen(fr1));

    opb_register_bank_simulink2ppc #(.C_DATA_WIDTH(12), .C_SIGN_EXT(1)) dut2 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dbo2), .Sl_xferAck(ack2),
        .Sl_errAck(err2), .Sl_retry(retry2), .Sl_toutSup(tout2), .user_data_in(ud2),
        .user_valid(uv), .frozen(fr2));

    function automatic logic [31:0] sx12(input logic [31:0] v);
        int s;
        s = int'(v & 32'hFFF);
        if (s >= 2048) s -= 4096;
        return 32'(s);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] off, input bit narrow);
        if (off == 0) return {31'd0, m_fz};
        if (off == 4) return {12'd0, m_ovf, 12'd0, m_new};
        if (off < 16) return 32'd0;
        if (off < 16 + 4 * N) return narrow ? sx12(m_ch[(off - 16) / 4]) : m_ch[(off - 16) / 4];
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_ch[k] = 0;
        m_new = 0; m_ovf = 0; m_fz = 0;
    endtask

    // One clock edge of the register bank as seen from the flag rules.
    task automatic model_edge(input logic [3:0] v, input logic [127:0] vd, input logic act,
                              input logic r, input logic [31:0] off, input logic [31:0] wd,
                              input logic [0:3] b);
        logic [3:0] old_new;
        logic old_fz;
        old_new = m_new;
        old_fz = m_fz;
        if (act && r && off >= 16 && off < 16 + 4 * N) m_new[(off - 16) / 4] = 1'b0;
        if (act && !r && off == 0 && b[3]) begin
            if (wd[1]) m_ovf = 0;
            m_fz = wd[0];
        end
        for (int k = 0; k < N; k++)
            if (v[k]) begin
                if (old_fz) m_ovf[k] = 1'b1;
                else begin
                    if (old_new[k]) m_ovf[k] = 1'b1;
                    m_ch[k] = vd[k*32 +: 32];
                    m_new[k] = 1'b1;
                end
            end
    endtask

    task automatic drive_user(input logic [3:0] v, input logic [127:0] vd);
        uv = v;
        ud1 = vd;
        for (int k = 0; k < N; k++) ud2[k*12 +: 12] = vd[k*32 +: 12];
    endtask

    task automatic pulse(input logic [3:0] v, input logic [127:0] vd);
        @(negedge clk);
        drive_user(v, vd);
        @(negedge clk);
        drive_user(4'd0, 128'd0);
        model_edge(v, vd, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic xfer(input logic [31:0] off, input logic r, input logic [31:0] wd,
                        input logic [0:3] b, input logic [3:0] v, input logic [127:0] vd,
                        input string nm);
        logic win, e;
        logic [31:0] x1, x2;
        win = off <= 32'hFF;
        x1 = exp_rd(off, 1'b0);
        x2 = exp_rd(off, 1'b1);
`ifdef OPB_REG_BANK_ERRACK_EN
        e = win && ((!r && off != 0) || off >= 16 + 4 * N);
`else
        e = 1'b0;
`endif
        if (!(win && r && !e)) begin x1 = 0; x2 = 0; end
        @(negedge clk);
        abus = BASE + off; rnw = r; dbus = wd; be = b; sel = 1'b1;
        drive_user(v, vd);
        compared++;
        if (ack1 !== 1'b0) begin mismatched++; $display("FAIL %s early_ack: got %b want 0", nm, ack1); end
        @(negedge clk);
        drive_user(4'd0, 128'd0);
        model_edge(v, vd, win, r, off, wd, b);
        compared++;
        if ({ack1, err1} !== {win, e}) begin
            mismatched++; $display("FAIL %s ack/err: got %b%b want %b%b", nm, ack1, err1, win, e);
        end
        compared++;
        if (dbo1 !== x1) begin mismatched++; $display("FAIL %s data: got %h want %h", nm, dbo1, x1); end
        compared++;
        if (dbo2 !== x2) begin mismatched++; $display("FAIL %s data12: got %h want %h", nm, dbo2, x2); end
        compared++;
        if ({fr1, fr2} !== {m_fz, m_fz}) begin
            mismatched++; $display("FAIL %s frozen: got %b%b want %b", nm, fr1, fr2, m_fz);
        end
        @(negedge clk);
        compared++;
        if ({ack1, err1, dbo1} !== 34'd0) begin
            mismatched++; $display("FAIL %s second_ack: got ack=%b err=%b data=%h want 0", nm, ack1, err1, dbo1);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({ack1, err1, dbo1, fr1, retry1, tout1} !== 36'd0) begin
            mismatched++; $display("FAIL reset_outputs: got ack=%b err=%b data=%h frozen=%b want 0", ack1, err1, dbo1, fr1);
        end
        rst = 1'b0;
        model_reset();
        xfer(32'h10, 1'b1, 0, 4'hF, 0, 0, "rst_ch0");
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "rst_status");
    endtask

    task automatic test_capture();
        pulse(4'b0100, {32'd0, 32'hDEADBEEF, 64'd0});
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "cap_status");
        xfer(32'h18, 1'b1, 0, 4'hF, 0, 0, "cap_ch2");
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "cap_status_clr");
    endtask

    task automatic test_overflow();
        pulse(4'b0010, {64'd0, 32'h11111111, 32'd0});
        pulse(4'b0010, {64'd0, 32'h22222222, 32'd0});
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "ovf_status");
        xfer(32'h00, 1'b0, 32'h2, 4'b0001, 0, 0, "ovf_clr_write");
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "ovf_status_clr");
        xfer(32'h14, 1'b1, 0, 4'hF, 0, 0, "ovf_ch1");
    endtask

    task automatic test_freeze();
        xfer(32'h00, 1'b0, 32'h1, 4'b0001, 0, 0, "frz_set");
        pulse(4'b0001, 128'h55);
        xfer(32'h10, 1'b1, 0, 4'hF, 0, 0, "frz_ch0");
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "frz_status");
        xfer(32'h00, 1'b1, 0, 4'hF, 0, 0, "frz_ctrl_rd");
        xfer(32'h00, 1'b0, 32'h0, 4'b1110, 0, 0, "frz_be_off");
        xfer(32'h00, 1'b0, 32'h0, 4'b0001, 0, 0, "frz_clear");
        pulse(4'b0001, 128'h66);
        xfer(32'h10, 1'b1, 0, 4'hF, 0, 0, "frz_resume_ch0");
    endtask

    task automatic test_collision();
        pulse(4'b1000, {32'h0ABC, 96'd0});
        xfer(32'h1C, 1'b1, 0, 4'hF, 4'b1000, {32'h1234, 96'd0}, "col_ch3_old");
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "col_status");
        xfer(32'h1C, 1'b1, 0, 4'hF, 0, 0, "col_ch3_new");
        pulse(4'b0001, 128'h800);
        xfer(32'h10, 1'b1, 0, 4'hF, 0, 0, "sext_ch0");
    endtask

    task automatic test_errack();
        xfer(32'h04, 1'b0, 32'hFFFFFFFF, 4'hF, 0, 0, "err_wr_status");
        xfer(32'h18, 1'b0, 32'hFFFFFFFF, 4'hF, 0, 0, "err_wr_ch2");
        xfer(32'h0C, 1'b0, 32'h12345678, 4'hF, 0, 0, "err_wr_rsvd");
        xfer(32'h08, 1'b1, 0, 4'hF, 0, 0, "err_rd_rsvd");
        xfer(32'h20, 1'b1, 0, 4'hF, 0, 0, "err_rd_beyond");
        xfer(32'h20, 1'b0, 32'h3, 4'hF, 0, 0, "err_wr_beyond");
        xfer(32'h100, 1'b1, 0, 4'hF, 0, 0, "out_of_window");
        xfer(32'h18, 1'b1, 0, 4'hF, 0, 0, "err_ch2_intact");
    endtask

    task automatic test_random();
        logic [31:0] off, wd;
        logic [127:0] vd;
        for (int i = 0; i < 300; i++) begin
            vd = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) pulse(4'($urandom), vd);
            else begin
                off = $urandom_range(0, 15) == 0 ? 32'h100 : 32'($urandom_range(0, 9) * 4);
                wd = off == 0 ? 32'($urandom_range(0, 3)) : $urandom;
                xfer(off, 1'($urandom), wd, 4'($urandom), 4'($urandom), vd, "rand");
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        xfer(32'h00, 1'b0, 32'h1, 4'b0001, 0, 0, "mid_freeze");
        pulse(4'b0100, {32'd0, 32'hCAFEF00D, 64'd0});
        @(negedge clk);
        abus = BASE + 32'h18; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        @(posedge clk);
        #2;
        compared++;
        if (ack1 !== 1'b1) begin mismatched++; $display("FAIL mid_ack_up: got %b want 1", ack1); end
        rst = 1'b1;
        #1;
        compared++;
        if ({ack1, err1, dbo1, fr1} !== 35'd0) begin
            mismatched++; $display("FAIL mid_reset: got ack=%b err=%b data=%h frozen=%b want 0", ack1, err1, dbo1, fr1);
        end
        @(negedge clk);
        sel = 1'b0;
        rst = 1'b0;
        model_reset();
        xfer(32'h04, 1'b1, 0, 4'hF, 0, 0, "mid_status");
        xfer(32'h18, 1'b1, 0, 4'hF, 0, 0, "mid_ch2");
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; rnw = 1'b1; seq = 1'b0; abus = 0; dbus = 0; be = 0;
        drive_user(4'd0, 128'd0);
        model_reset();
        test_reset();
        test_capture();
        test_overflow();
        test_freeze();
        test_collision();
        test_errack();
        test_random();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
